// File: rtl/mem_dual_arbiter.sv
// Shares one dual-ported memory (registered read) between REQS requesters with round-robin arbitration.
// After reset the memory is zero-filled two words per cycle before any request is accepted.
module mem_dual_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int REQS  = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int PW   = $clog2(REQS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [REQS-1:0]         req_valid,
  output logic [REQS-1:0]         req_ready,
  input  logic [REQS-1:0]         req_write,
  input  logic [REQS*AW-1:0]      req_addr,
  input  logic [REQS*WIDTH-1:0]   req_data,
  output logic [REQS-1:0]         rsp_valid,
  output logic [REQS*WIDTH-1:0]   rsp_data,
  output logic                    busy,
  output logic [AW-1:0]           mem_address_0,
  output logic [AW-1:0]           mem_address_1,
  output logic [WIDTH-1:0]        mem_data_0,
  output logic [WIDTH-1:0]        mem_data_1,
  output logic                    mem_wren_0,
  output logic                    mem_wren_1,
  input  logic [WIDTH-1:0]        mem_q_0,
  input  logic [WIDTH-1:0]        mem_q_1
);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   clear_addr_reg, clear_addr_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic            rd0_valid_reg, rd0_valid_next;
  logic            rd1_valid_reg, rd1_valid_next;
  logic [PW-1:0]   rd0_idx_reg, rd0_idx_next;
  logic [PW-1:0]   rd1_idx_reg, rd1_idx_next;

  logic [AW-1:0]    addr_arr [REQS];
  logic [WIDTH-1:0] data_arr [REQS];

  logic            run;
  logic            found_a, found_b;
  logic [PW-1:0]   idx_a, idx_b;
  logic            hazard;
  logic            grant_a, grant_b;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (i == PW'(REQS - 1)) ? '0 : i + PW'(1);
  endfunction

  generate
    for (genvar gi = 0; gi < REQS; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*AW +: AW];
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Rotating scan from ptr: the first valid requester takes port 0, the second port 1.
  always_comb begin : arb_scan
    int            s;
    logic [PW-1:0] cand;
    found_a = 1'b0;
    found_b = 1'b0;
    idx_a   = '0;
    idx_b   = '0;
    for (int k = 0; k < REQS; k++) begin
      s = int'(ptr_reg) + k;
      if (s >= REQS) s = s - REQS;
      cand = PW'(s);
      if (req_valid[cand]) begin
        if (!found_a) begin
          found_a = 1'b1;
          idx_a   = cand;
        end else if (!found_b) begin
          found_b = 1'b1;
          idx_b   = cand;
        end
      end
    end
  end

  assign run     = (state_reg == ST_RUN);
  assign hazard  = found_b && (addr_arr[idx_a] == addr_arr[idx_b]) &&
                   (req_write[idx_a] || req_write[idx_b]);
  assign grant_a = run && found_a;
  assign grant_b = run && found_b && !hazard;

  always_comb begin
    state_next      = state_reg;
    clear_addr_next = clear_addr_reg;
    ptr_next        = ptr_reg;
    rd0_valid_next  = 1'b0;
    rd1_valid_next  = 1'b0;
    rd0_idx_next    = rd0_idx_reg;
    rd1_idx_next    = rd1_idx_reg;
    busy            = 1'b0;
    mem_address_0   = '0;
    mem_address_1   = '0;
    mem_data_0      = '0;
    mem_data_1      = '0;
    mem_wren_0      = 1'b0;
    mem_wren_1      = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        busy          = 1'b1;
        mem_address_0 = clear_addr_reg;
        // clear_addr is always even, so OR-ing in bit 0 gives the odd neighbour
        mem_address_1 = clear_addr_reg | AW'(1);
        mem_wren_0    = 1'b1;
        mem_wren_1    = 1'b1;
        if (clear_addr_reg == AW'(DEPTH - 2)) begin
          state_next = ST_RUN;
        end else begin
          clear_addr_next = clear_addr_reg + AW'(2);
        end
      end
      ST_RUN: begin
        if (grant_a) begin
          mem_address_0  = addr_arr[idx_a];
          mem_data_0     = data_arr[idx_a];
          mem_wren_0     = req_write[idx_a];
          rd0_valid_next = !req_write[idx_a];
          rd0_idx_next   = idx_a;
        end
        if (grant_b) begin
          mem_address_1  = addr_arr[idx_b];
          mem_data_1     = data_arr[idx_b];
          mem_wren_1     = req_write[idx_b];
          rd1_valid_next = !req_write[idx_b];
          rd1_idx_next   = idx_b;
        end
        if (grant_b) begin
          ptr_next = wrap_inc(idx_b);
        end else if (grant_a) begin
          ptr_next = wrap_inc(idx_a);
        end
      end
      default: state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= ST_CLEAR;
      clear_addr_reg <= '0;
      ptr_reg        <= '0;
      rd0_valid_reg  <= 1'b0;
      rd1_valid_reg  <= 1'b0;
      rd0_idx_reg    <= '0;
      rd1_idx_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      clear_addr_reg <= clear_addr_next;
      ptr_reg        <= ptr_next;
      rd0_valid_reg  <= rd0_valid_next;
      rd1_valid_reg  <= rd1_valid_next;
      rd0_idx_reg    <= rd0_idx_next;
      rd1_idx_reg    <= rd1_idx_next;
    end
  end

  // Port tags registered at acceptance route the memory's read data back a cycle later.
  generate
    for (genvar gi = 0; gi < REQS; gi++) begin : g_req
      localparam logic [PW-1:0] IDX = PW'(gi);
      logic hit0, hit1;
      assign hit0          = rd0_valid_reg && (rd0_idx_reg == IDX);
      assign hit1          = rd1_valid_reg && (rd1_idx_reg == IDX);
      assign rsp_valid[gi] = hit0 || hit1;
      assign rsp_data[gi*WIDTH +: WIDTH] = hit0 ? mem_q_0 : (hit1 ? mem_q_1 : '0);
      assign req_ready[gi] = (grant_a && (idx_a == IDX)) || (grant_b && (idx_b == IDX));
    end
  endgenerate

endmodule

// File: doc/mem_dual_arbiter.md
Name: mem_dual_arbiter

Overview:
- Shares one dual-ported memory (2 ports, 1-cycle registered read) between REQS requesters using round-robin arbitration.
- Each cycle, up to two requests are mapped onto port 0 and port 1. A same-address hazard between the two grants is resolved by deferring the second.
- After reset, a clear sequencer zero-fills the whole memory through both ports before any request is accepted.
- Sits between client engines and the memory instance; it owns every memory port signal.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 64, memory words. Must be even and ≥2. Address width AW = CLOG2(DEPTH), derived.
- REQS, 4, number of requesters, 2..8.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  REQS  request present, per requester.
- req_ready  out  REQS  request accepted this cycle; transfer = valid & ready.
- req_write  in  REQS  1 = write, 0 = read.
- req_addr  in  REQS*AW  address; slice i = [i*AW +: AW].
- req_data  in  REQS*WIDTH  write data; slice i = [i*WIDTH +: WIDTH].
- rsp_valid  out  REQS  read data valid for requester i.
- rsp_data  out  REQS*WIDTH  read data; slice i meaningful only when rsp_valid[i].
- busy  out  1  high while the clear sequence runs.
- mem_address_0, mem_address_1  out  AW  memory addresses.
- mem_data_0, mem_data_1  out  WIDTH  memory write data.
- mem_wren_0, mem_wren_1  out  1  memory write enables.
- mem_q_0, mem_q_1  in  WIDTH  memory read data, one cycle after the address.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state = CLEAR, clear_addr = 0, ptr = 0, rsp_valid = 0, req_ready = 0, busy = 1.
- FSM CLEAR:
  - port 0 writes 0 to clear_addr; port 1 writes 0 to clear_addr+1. Both wren = 1.
  - clear_addr += 2 each cycle.
  - After the cycle that writes DEPTH-2 and DEPTH-1, go to RUN. CLEAR lasts exactly DEPTH/2 cycles.
  - req_ready = 0 throughout.
- FSM RUN: busy = 0. No exit except reset.
- Arbitration in RUN (combinational, same cycle as valid):
  - Scan indices ptr, ptr+1, … mod REQS.
  - First valid requester = A, driven onto port 0. Next valid = B, driven onto port 1.
  - Hazard: if addr(A) == addr(B) and (write(A) or write(B)), B is not granted this cycle.
  - req_ready is high only for granted requesters, and never without req_valid.
- Memory drive:
  - Granted request: address, data and wren = write bit go to its port.
  - Idle port: wren = 0, address = 0, data = 0.
- Pointer: after any grant, ptr <= (index of last granted requester + 1) mod REQS. With no grant, ptr holds.
- Read response:
  - Accepted read by requester i on port p at cycle t gives rsp_valid[i] = 1 at t+1 for one cycle, with rsp_data slice i = mem_q_p.
  - Port tags are registered at t.
  - Writes produce no response.
- Back-to-back ordering: a read at t+1 to an address written at t returns the new data; this follows from the memory write/read ordering.
- Read-read on the same address: both granted, both get the same data.
- Reset mid-operation (CLEAR or RUN): rsp_valid pending from the previous cycle is dropped (0 on the next cycle). The clear restarts at address 0 and ptr = 0.
- A requester may be granted at most once per cycle. Requesters hold req_valid and payload until ready.

Test Plan:
- Reset, then idle: DEPTH=64 → busy high for exactly 32 cycles. Port 0 addresses 0,2,…,62, port 1 addresses 1,3,…,63, all data 0. Then busy = 0. A subsequent read of any address returns 0.
- Requesters 0..3 all valid, writing addr 4*i with data 0xA0+i: cycle 1 grants 0 (port 0) and 1 (port 1); cycle 2 grants 2 and 3. Then reads of addresses 0, 4, 8, 12 return 0xA0..0xA3 with rsp_valid one cycle after ready.
- Requester 1 writes 0x55 to addr 7 while requester 2 reads addr 7, ptr = 1: only requester 1 ready in cycle 1. Requester 2 ready in cycle 2 and gets rsp_data = 0x55 in cycle 3.
- Requesters 0 and 3 both read addr 9 (holding 0x3C) in the same cycle: both ready, both rsp_valid next cycle with 0x3C.
- Fairness: all 4 requesters continuously valid with distinct reads for 8 cycles → each requester granted exactly 4 times. Grant pairs rotate (0,1), (2,3), (0,1), …
- Assert reset during RUN one cycle after a read is accepted: rsp_valid stays 0, busy returns high, and the clear replays for 32 cycles from address 0.
